// File: rtl/register_array_sequencer.sv
module register_array_sequencer #(
  parameter int unsigned num_qubit  = 4,
  parameter int unsigned max_vector = 2**num_qubit
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [31:0]              cmd_count,
  input  logic                     row_valid,
  output logic                     row_ready,
  input  logic [2*num_qubit-1:0]   row_literals,
  input  logic [max_vector-1:0]    row_phase,
  output logic                     ld_reg,
  output logic [1:0]               shift_rotate_array,
  output logic [2*num_qubit-1:0]   literals_in,
  output logic [max_vector-1:0]    phase_in,
  output logic                     busy,
  output logic                     done,
  output logic                     cmd_err,
  output logic [31:0]              steps_done
);

  localparam int unsigned RW = $clog2(num_qubit + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROTR,
    S_ROTC,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   remaining_q, remaining_d;
  logic [31:0]     steps_q, steps_d;
  logic            err_q, err_d;
  logic [RW-1:0]   eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      steps_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      steps_q     <= steps_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    remaining_d        = remaining_q;
    steps_d            = steps_q;
    err_d              = err_q;
    cmd_ready          = 1'b0;
    row_ready          = 1'b0;
    busy               = 1'b0;
    ld_reg             = 1'b0;
    shift_rotate_array = 2'd0;
    literals_in        = '0;
    phase_in           = '0;
    // A full rotation is the identity, so only the residue needs stepping.
    eff                = RW'(cmd_count % num_qubit);

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          steps_d = '0;
          err_d   = 1'b0;
          case (cmd_op)
            2'd0: begin
              remaining_d = RW'(num_qubit);
              state_d     = S_LOAD;
            end
            2'd1, 2'd2: begin
              if (eff == '0) begin
                state_d = S_DONE;
              end else begin
                remaining_d = eff;
                state_d     = (cmd_op == 2'd1) ? S_ROTR : S_ROTC;
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end

      S_LOAD: begin
        busy        = 1'b1;
        row_ready   = 1'b1;
        ld_reg      = row_valid;
        literals_in = row_literals;
        phase_in    = row_phase;
        if (row_valid) begin
          remaining_d = remaining_q - RW'(1);
          steps_d     = steps_q + 32'd1;
          if (remaining_q == RW'(1)) state_d = S_DONE;
        end
      end

      S_ROTR, S_ROTC: begin
        busy               = 1'b1;
        ld_reg             = 1'b1;
        shift_rotate_array = (state_q == S_ROTR) ? 2'd1 : 2'd2;
        remaining_d        = remaining_q - RW'(1);
        steps_d            = steps_q + 32'd1;
        if (remaining_q == RW'(1)) state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign done       = (state_q == S_DONE);
  assign cmd_err    = (state_q == S_DONE) && err_q;
  assign steps_done = steps_q;

endmodule

// File: tb/tb_register_array_sequencer.sv
module tb_register_array_sequencer;

  localparam int unsigned N  = 4;
  localparam int unsigned MV = 2**N;
  localparam int unsigned LW = 2*N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [31:0]   cmd_count = '0;
  logic          row_valid = 1'b0;
  logic          row_ready;
  logic [LW-1:0] row_literals = '0;
  logic [MV-1:0] row_phase = '0;
  logic          ld_reg;
  logic [1:0]    shift_rotate_array;
  logic [LW-1:0] literals_in;
  logic [MV-1:0] phase_in;
  logic          busy;
  logic          done;
  logic          cmd_err;
  logic [31:0]   steps_done;

  register_array_sequencer #(.num_qubit(N), .max_vector(MV)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_count(cmd_count),
    .row_valid(row_valid), .row_ready(row_ready),
    .row_literals(row_literals), .row_phase(row_phase),
    .ld_reg(ld_reg), .shift_rotate_array(shift_rotate_array),
    .literals_in(literals_in), .phase_in(phase_in),
    .busy(busy), .done(done), .cmd_err(cmd_err), .steps_done(steps_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Downstream stabilizer array driven by the sequencer outputs.
  logic [LW-1:0] arr_lit [N];
  logic [MV-1:0] arr_ph  [N];

  always @(posedge clk) begin
    if (ld_reg === 1'b1) begin
      case (shift_rotate_array)
        2'd0: begin
          for (int i = 1; i < int'(N); i++) begin
            arr_lit[i] <= arr_lit[i-1];
            arr_ph[i]  <= arr_ph[i-1];
          end
          arr_lit[0] <= literals_in;
          arr_ph[0]  <= phase_in;
        end
        2'd1: begin
          for (int i = 0; i < int'(N); i++) begin
            arr_lit[i] <= arr_lit[(i + int'(N) - 1) % int'(N)];
            arr_ph[i]  <= arr_ph[(i + int'(N) - 1) % int'(N)];
          end
        end
        2'd2: begin
          for (int i = 0; i < int'(N); i++)
            arr_lit[i] <= {arr_lit[i][1:0], arr_lit[i][LW-1:2]};
        end
        default: ;
      endcase
    end
  end

  logic [LW-1:0] row_lit [N];
  logic [MV-1:0] row_ph  [N];

  int obs_strobes, obs_done_lat, obs_steps, obs_bad, obs_accept_cyc, obs_last_strobe_cyc;
  logic obs_ready, obs_err;

  task automatic make_rows(input bit randomize_rows);
    for (int k = 0; k < int'(N); k++) begin
      if (randomize_rows) begin
        row_lit[k] = LW'($urandom);
        row_ph[k]  = MV'($urandom);
      end else begin
        for (int c = 0; c < int'(N); c++)
          row_lit[k][2*c +: 2] = 2'((c + k) % 4);
        row_ph[k] = '0;
        row_ph[k][k] = 1'b1;
      end
    end
  endtask

  // Issues one command and watches it to completion; deviations from the
  // expected per-cycle behaviour accumulate in obs_bad.
  task automatic exec_cmd(input logic [1:0] op, input logic [31:0] count, input int mode);
    int   needed, sent;
    logic rv, exp_ld;
    bit   finished;
    needed = (op == 2'd0) ? int'(N) : (op == 2'd3) ? 0 : int'(count % N);
    obs_strobes = 0; obs_done_lat = -1; obs_steps = -1; obs_bad = 0;
    obs_last_strobe_cyc = -1; obs_err = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_count = count; row_valid = 1'b0;
    #1;
    obs_ready = cmd_ready;
    obs_accept_cyc = cyc;
    sent = 0;
    finished = 0;
    for (int t = 1; t <= 40 && !finished; t++) begin
      @(negedge clk);
      cmd_op    = 2'($urandom);
      cmd_count = $urandom;
      case (mode)
        0:       rv = 1'b1;
        1:       rv = (t % 2 == 1);
        default: rv = 1'($urandom_range(0, 1));
      endcase
      if (op != 2'd0) rv = 1'($urandom_range(0, 1));
      row_valid = rv;
      if (op == 2'd0 && rv && sent < needed) begin
        row_literals = row_lit[sent];
        row_phase    = row_ph[sent];
      end else begin
        row_literals = LW'($urandom);
        row_phase    = MV'($urandom);
      end
      #1;
      if (ld_reg === 1'b1) begin
        obs_strobes++;
        obs_last_strobe_cyc = cyc;
      end
      if (sent < needed) begin
        exp_ld = (op == 2'd0) ? rv : 1'b1;
        if (busy !== 1'b1 || done !== 1'b0 || cmd_err !== 1'b0 || cmd_ready !== 1'b0 ||
            steps_done !== 32'(sent) || ld_reg !== exp_ld) begin
          obs_bad++;
          $display("  diverged op=%0d cycle %0d: busy=%b done=%b ld=%b steps=%0d (sent %0d)",
                   op, t, busy, done, ld_reg, steps_done, sent);
        end
        if (op == 2'd0) begin
          if (row_ready !== 1'b1) obs_bad++;
          if (rv && (shift_rotate_array !== 2'd0 || literals_in !== row_lit[sent] ||
                     phase_in !== row_ph[sent])) begin
            obs_bad++;
            $display("  data diverged cycle %0d: lit=%h phase=%h", t, literals_in, phase_in);
          end
        end else begin
          if (row_ready !== 1'b0 || shift_rotate_array !== op ||
              literals_in !== '0 || phase_in !== '0) obs_bad++;
        end
        if (exp_ld) sent++;
      end else begin
        if (done !== 1'b1 || busy !== 1'b0 || ld_reg !== 1'b0 || cmd_ready !== 1'b0 ||
            row_ready !== 1'b0 || cmd_err !== (op == 2'd3)) begin
          obs_bad++;
          $display("  completion cycle diverged: done=%b busy=%b ld=%b err=%b", done, busy, ld_reg, cmd_err);
        end
        obs_done_lat = t;
        obs_steps    = int'(steps_done);
        obs_err      = cmd_err;
        cmd_valid    = 1'b0;
        finished     = 1;
      end
    end
    cmd_valid = 1'b0;
    if (!finished) obs_bad++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0 || cmd_err !== 1'b0) begin errors++; $display("FAIL reset_done_err got=%b%b want=00", done, cmd_err); end
    checks++; if (steps_done !== 32'd0) begin errors++; $display("FAIL reset_steps got=%0d want=0", steps_done); end
    checks++; if (ld_reg !== 1'b0 || row_ready !== 1'b0) begin errors++; $display("FAIL reset_strobes got=%b%b want=00", ld_reg, row_ready); end
    rst = 1'b0;
  endtask

  task automatic test_load_back_to_back;
    make_rows(0);
    exec_cmd(2'd0, 32'd0, 0);
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL load_b2b_accept got=%b want=1", obs_ready); end
    checks++; if (obs_bad != 0) begin errors++; $display("FAIL load_b2b_cycles got=%0d bad want=0", obs_bad); end
    checks++; if (obs_strobes != 4) begin errors++; $display("FAIL load_b2b_strobes got=%0d want=4", obs_strobes); end
    checks++; if (obs_done_lat != 5) begin errors++; $display("FAIL load_b2b_done_lat got=%0d want=5", obs_done_lat); end
    checks++; if (obs_steps != 4) begin errors++; $display("FAIL load_b2b_steps got=%0d want=4", obs_steps); end
    checks++; if (arr_lit[N-1] !== row_lit[0] || arr_ph[N-1] !== row_ph[0]) begin
      errors++; $display("FAIL load_b2b_last_row got=%h/%h want=%h/%h", arr_lit[N-1], arr_ph[N-1], row_lit[0], row_ph[0]);
    end
    checks++; if (arr_lit[0] !== row_lit[N-1] || arr_ph[0] !== row_ph[N-1]) begin
      errors++; $display("FAIL load_b2b_first_row got=%h/%h want=%h/%h", arr_lit[0], arr_ph[0], row_lit[N-1], row_ph[N-1]);
    end
  endtask

  task automatic test_load_stall;
    make_rows(1);
    exec_cmd(2'd0, 32'd0, 1);
    checks++; if (obs_bad != 0) begin errors++; $display("FAIL load_stall_cycles got=%0d bad want=0", obs_bad); end
    checks++; if (obs_strobes != 4) begin errors++; $display("FAIL load_stall_strobes got=%0d want=4", obs_strobes); end
    checks++; if (obs_done_lat != 8) begin errors++; $display("FAIL load_stall_done_lat got=%0d want=8", obs_done_lat); end
    checks++; if (obs_steps != 4) begin errors++; $display("FAIL load_stall_steps got=%0d want=4", obs_steps); end
  endtask

  task automatic test_load_random;
    int mism;
    for (int it = 0; it < 4; it++) begin
      make_rows(1);
      exec_cmd(2'd0, $urandom, 2);
      mism = 0;
      for (int i = 0; i < int'(N); i++)
        if (arr_lit[i] !== row_lit[N-1-i] || arr_ph[i] !== row_ph[N-1-i]) mism++;
      checks++; if (obs_bad != 0 || obs_strobes != 4) begin
        errors++; $display("FAIL load_rand_run got=%0d bad/%0d strobes want=0/4", obs_bad, obs_strobes);
      end
      checks++; if (mism != 0) begin errors++; $display("FAIL load_rand_array got=%0d rows wrong want=0", mism); end
    end
  endtask

  task automatic test_rotate_rows;
    logic [LW-1:0] bl [N];
    logic [MV-1:0] bp [N];
    int mism;
    for (int i = 0; i < int'(N); i++) begin bl[i] = arr_lit[i]; bp[i] = arr_ph[i]; end
    exec_cmd(2'd1, 32'd6, 2);
    checks++; if (obs_bad != 0) begin errors++; $display("FAIL rotr_cycles got=%0d bad want=0", obs_bad); end
    checks++; if (obs_strobes != 2) begin errors++; $display("FAIL rotr_strobes got=%0d want=2", obs_strobes); end
    checks++; if (obs_done_lat != 3) begin errors++; $display("FAIL rotr_done_lat got=%0d want=3", obs_done_lat); end
    checks++; if (obs_steps != 2) begin errors++; $display("FAIL rotr_steps got=%0d want=2", obs_steps); end
    mism = 0;
    for (int i = 0; i < int'(N); i++)
      if (arr_lit[i] !== bl[(i + int'(N) - 2) % int'(N)] || arr_ph[i] !== bp[(i + int'(N) - 2) % int'(N)]) mism++;
    checks++; if (mism != 0) begin errors++; $display("FAIL rotr_array got=%0d rows wrong want=0", mism); end
  endtask

  task automatic test_rotate_cols_identity;
    exec_cmd(2'd2, 32'd8, 2);
    checks++; if (obs_strobes != 0) begin errors++; $display("FAIL rotc8_strobes got=%0d want=0", obs_strobes); end
    checks++; if (obs_done_lat != 1) begin errors++; $display("FAIL rotc8_done_lat got=%0d want=1", obs_done_lat); end
    checks++; if (obs_steps != 0) begin errors++; $display("FAIL rotc8_steps got=%0d want=0", obs_steps); end
    checks++; if (obs_bad != 0 || obs_err !== 1'b0) begin errors++; $display("FAIL rotc8_cycles got=%0d bad err=%b want=0/0", obs_bad, obs_err); end
  endtask

  task automatic test_rotate_random;
    logic [1:0]  op;
    logic [31:0] cnt;
    int eff;
    for (int it = 0; it < 8; it++) begin
      op  = (it % 2 == 0) ? 2'd1 : 2'd2;
      cnt = (it < 2) ? 32'(it + 4) : $urandom;
      eff = int'(cnt % N);
      exec_cmd(op, cnt, 2);
      checks++; if (obs_bad != 0 || obs_strobes != eff || obs_done_lat != eff + 1 || obs_steps != eff) begin
        errors++;
        $display("FAIL rot_rand op=%0d cnt=%0d got bad=%0d strobes=%0d lat=%0d steps=%0d want 0/%0d/%0d/%0d",
                 op, cnt, obs_bad, obs_strobes, obs_done_lat, obs_steps, eff, eff + 1, eff);
      end
    end
  endtask

  task automatic test_reserved_op;
    exec_cmd(2'd3, $urandom, 2);
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL op3_cmd_err got=%b want=1", obs_err); end
    checks++; if (obs_done_lat != 1) begin errors++; $display("FAIL op3_done_lat got=%0d want=1", obs_done_lat); end
    checks++; if (obs_strobes != 0 || obs_bad != 0) begin errors++; $display("FAIL op3_clean got=%0d strobes/%0d bad want=0/0", obs_strobes, obs_bad); end
    @(negedge clk); #1;
    checks++; if (cmd_err !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL op3_pulse_width got=err%b done%b rdy%b want=err0 done0 rdy1", cmd_err, done, cmd_ready);
    end
  endtask

  task automatic test_back_to_back;
    int last_a;
    exec_cmd(2'd1, 32'd3, 2);
    last_a = obs_last_strobe_cyc;
    make_rows(1);
    exec_cmd(2'd0, 32'd0, 0);
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b want=1", obs_ready); end
    checks++; if (obs_accept_cyc - last_a != 2) begin errors++; $display("FAIL b2b_gap got=%0d want=2", obs_accept_cyc - last_a); end
    checks++; if (obs_bad != 0 || obs_done_lat != 5) begin errors++; $display("FAIL b2b_second got=%0d bad lat=%0d want=0/5", obs_bad, obs_done_lat); end
  endtask

  task automatic test_reset_mid_load;
    make_rows(1);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; row_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0; row_valid = 1'b1;
      row_literals = row_lit[k]; row_phase = row_ph[k];
    end
    @(negedge clk);
    row_valid = 1'b0; rst = 1'b1;
    #1;
    checks++; if (steps_done !== 32'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_pre_reset got steps=%0d busy=%b want 2/1", steps_done, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || steps_done !== 32'd0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_reset_idle got rdy=%b busy=%b steps=%0d done=%b want 1/0/0/0", cmd_ready, busy, steps_done, done);
    end
    make_rows(0);
    exec_cmd(2'd0, 32'd0, 0);
    checks++; if (obs_bad != 0 || obs_strobes != 4 || obs_done_lat != 5 || obs_steps != 4) begin
      errors++; $display("FAIL mid_reset_reload got bad=%0d strobes=%0d lat=%0d steps=%0d want 0/4/5/4",
                         obs_bad, obs_strobes, obs_done_lat, obs_steps);
    end
    checks++; if (arr_lit[N-1] !== row_lit[0]) begin errors++; $display("FAIL mid_reset_last_row got=%h want=%h", arr_lit[N-1], row_lit[0]); end
  endtask

  initial begin
    test_reset();
    test_load_back_to_back();
    test_load_stall();
    test_load_random();
    test_rotate_rows();
    test_rotate_cols_identity();
    test_rotate_random();
    test_reserved_op();
    test_back_to_back();
    test_reset_mid_load();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
